// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 decode-side immediate path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msrv32_pkg;

  // Immediate type select codes; 000, 001 and 111 all decode as I-type.
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_I2  = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;
  localparam logic [2:0] IMM_I3  = 3'b111;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_TAG_W = 8;

endpackage

// File: rtl/msrv32_imm_expand.sv
// Expands instr[31:7] into an XLEN-wide immediate according to the type select.
// Latency: purely combinational.
// Backpressure: none; stateless.
module msrv32_imm_expand
  import msrv32_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [24:0]     instr,     // instruction bits [31:7]; bit k lives at instr[k-7]
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("msrv32_imm_expand: XLEN must be 32 or 64");
    end
  endgenerate

  logic sign;
  assign sign = instr[24];

  // Start from all sign bits and overwrite the low field, so every type
  // except the CSR zimm is sign-extended to the full XLEN.
  always_comb begin
    imm = {XLEN{sign}};
    case (imm_type)
      IMM_S:   imm[11:0] = {instr[24:18], instr[4:0]};
      IMM_B:   imm[12:0] = {instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_U:   imm[31:0] = {instr[24:5], 12'h000};
      IMM_J:   imm[20:0] = {instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_CSR: begin
        imm      = '0;
        imm[4:0] = instr[12:8];
      end
      default: imm[11:0] = instr[24:13];
    endcase
  end

endmodule

// File: rtl/msrv32_imm_gen_stage.sv
// Pipelined immediate generator: expands, then registers immediate + tag behind valid/ready.
// Latency: 1 cycle from acceptance to out_valid when the output register is free.
// Backpressure: SKID_EN=1 absorbs one extra entry, in_ready = !skid_valid (registered); SKID_EN=0 single stage.
module msrv32_imm_gen_stage
  import msrv32_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int TAG_W   = DEFAULT_TAG_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy_out
);

  logic [XLEN-1:0]  imm_exp;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_valid;
  logic             push;

  // Expansion sits on the input side so both registers hold finished immediates.
  msrv32_imm_expand #(
    .XLEN (XLEN)
  ) u_expand (
    .instr    (instr_in),
    .imm_type (imm_type_in),
    .imm      (imm_exp)
  );

  // With the skid enabled, ready depends only on state, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready = SKID_EN ? !skid_valid : (!out_valid || out_ready);
  assign push     = in_valid && in_ready;
  assign busy_out = out_valid || skid_valid;

  // Output register and skid entry; flush beats everything, then the output
  // register refills from the skid (oldest first), else the skid catches a stalled push.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      out_valid  <= 1'b0;
      imm_out    <= '0;
      tag_out    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
    end else if (flush_in) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        imm_out   <= skid_imm;
        tag_out   <= skid_tag;
        if (push) begin
          skid_imm <= imm_exp;
          skid_tag <= tag_in;
        end else begin
          skid_valid <= 1'b0;
        end
      end else begin
        out_valid <= push;
        if (push) begin
          imm_out <= imm_exp;
          tag_out <= tag_in;
        end
      end
    end else if (push && SKID_EN) begin
      skid_valid <= 1'b1;
      skid_imm   <= imm_exp;
      skid_tag   <= tag_in;
    end
  end

endmodule

// File: tb/tb_msrv32_imm_gen_stage.sv
// Bench for msrv32_imm_gen_stage: XLEN=32/SKID_EN=1 and XLEN=64/SKID_EN=0 share one stimulus.
// Latency: expects results 1 cycle after acceptance.
// Backpressure: a queue model per instance predicts valid, ready, busy and data every cycle.
module tb_msrv32_imm_gen_stage;
  import msrv32_pkg::*;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [24:0]   instr = '0;
  logic [2:0]    typ = '0;
  logic [TW-1:0] tag_in = '0;

  logic          ir0, ov0, busy0;
  logic [31:0]   imm0;
  logic [TW-1:0] tag0;
  logic          ir1, ov1, busy1;
  logic [63:0]   imm1;
  logic [TW-1:0] tag1;

  int total = 0;
  int bad   = 0;
  int xfer [2];

  typedef struct packed {
    logic [63:0]   imm;
    logic [TW-1:0] tag;
  } ent_t;
  ent_t q [2][$];

  always #5 clk = ~clk;

  msrv32_imm_gen_stage #(.XLEN(32), .TAG_W(TW), .SKID_EN(1'b1)) u0 (
    .ms_riscv32_mp_clk_in (clk), .ms_riscv32_mp_rst_in (rst), .flush_in (flush),
    .in_valid (in_valid), .in_ready (ir0), .instr_in (instr), .imm_type_in (typ),
    .tag_in (tag_in), .out_valid (ov0), .out_ready (out_ready), .imm_out (imm0),
    .tag_out (tag0), .busy_out (busy0)
  );

  msrv32_imm_gen_stage #(.XLEN(64), .TAG_W(TW), .SKID_EN(1'b0)) u1 (
    .ms_riscv32_mp_clk_in (clk), .ms_riscv32_mp_rst_in (rst), .flush_in (flush),
    .in_valid (in_valid), .in_ready (ir1), .instr_in (instr), .imm_type_in (typ),
    .tag_in (tag_in), .out_valid (ov1), .out_ready (out_ready), .imm_out (imm1),
    .tag_out (tag1), .busy_out (busy1)
  );

  // Reference expansion from the field rules using signed arithmetic.
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] t, input int xlen);
    longint s, v;
    s = longint'($signed(ins));
    case (t)
      IMM_S:   v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      IMM_B:   v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                   | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      IMM_U:   v = (s >>> 12) <<< 12;
      IMM_J:   v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                   | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      IMM_CSR: v = longint'(ins[19:15]);
      default: v = s >>> 20;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instance's view of the coming clock edge: check, then pop/flush/push.
  task automatic mon(input int id, input bit skid, input logic ir, input logic ov, input logic busy,
                     input logic [63:0] imm, input logic [TW-1:0] tg, input int xlen);
    string nm;
    int    sz;
    ent_t  e;
    nm = (id == 0) ? "u32" : "u64";
    sz = q[id].size();
    chk({nm, "_in_ready"}, ir, skid ? (sz < 2) : (sz == 0 || out_ready));
    chk({nm, "_out_valid"}, ov, sz != 0);
    chk({nm, "_busy"}, busy, sz != 0);
    if (ov && sz != 0) begin
      chk({nm, "_imm"}, imm, q[id][0].imm);
      chk({nm, "_tag"}, tg, q[id][0].tag);
      if (out_ready) begin
        void'(q[id].pop_front());
        xfer[id]++;
      end
    end
    if (flush) begin
      q[id].delete();
    end else if (in_valid && ir) begin
      e.imm = model({instr, 7'b0}, typ, xlen);
      e.tag = tag_in;
      q[id].push_back(e);
    end
  endtask

  // Compare process: inputs and outputs are both settled at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q[0].delete();
      q[1].delete();
    end else begin
      mon(0, 1'b1, ir0, ov0, busy0, {32'b0, imm0}, tag0, 32);
      mon(1, 1'b0, ir1, ov1, busy1, imm1, tag1, 64);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] d_ins [9] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'h001000EF,
                             32'h800F8073, 32'h800000B7, 32'hFFF00093, 32'h7FF00093};
  logic [2:0]  d_t   [9] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b100, 3'b111, 3'b001};
  logic [63:0] d_exp [9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8,
                             64'h0000_0000_1234_5000, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_001F,
                             64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_07FF};

  logic [TW-1:0] got [$];

  initial begin
    int  nxt, cyc;
    bit  acc, pop;
    logic [TW-1:0] t;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_imm", {32'b0, imm0}, 64'd0);
    chk("rst_tag", tag0, 8'd0);
    chk("rst_imm64", imm1, 64'd0);
    #10 rst = 1'b0;
    step();
    chk("post_rst_in_ready32", ir0, 1'b1);
    chk("post_rst_in_ready64", ir1, 1'b1);

    // Directed expansions, each visible one cycle after acceptance
    for (int i = 0; i < 9; i++) begin
      instr    = d_ins[i][31:7];
      typ      = d_t[i];
      tag_in   = TW'(i + 1);
      in_valid = 1'b1;
      chk("model_pin", model(d_ins[i], d_t[i], 64), d_exp[i]);
      step();
      chk("dir_valid32", ov0, 1'b1);
      chk("dir_imm32", {32'b0, imm0}, {32'b0, d_exp[i][31:0]});
      chk("dir_tag32", tag0, TW'(i + 1));
      chk("dir_valid64", ov1, 1'b1);
      chk("dir_imm64", imm1, d_exp[i]);
      chk("dir_tag64", tag1, TW'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("dir_drained", ov0, 1'b0);

    // Sustained throughput with out_ready held high
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr  = 25'($urandom);
      typ    = 3'($urandom_range(0, 7));
      tag_in = TW'(8'h80 + i);
      step();
      chk("tput_valid32", ov0, 1'b1);
      chk("tput_valid64", ov1, 1'b1);
      chk("tput_ready32", ir0, 1'b1);
      chk("tput_ready64", ir1, 1'b1);
    end
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: tags 1..6, out_ready low for cycles 2..5
    nxt = 1;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (nxt <= 6);
      tag_in    = TW'(nxt);
      instr     = 25'($urandom);
      typ       = 3'($urandom_range(0, 7));
      chk("bp_in_ready", ir0, !(c >= 3 && c <= 6));
      if (c >= 2 && c <= 6) chk("bp_hold_tag", tag0, 8'd2);
      acc = in_valid && ir0;
      pop = ov0 && out_ready;
      t   = tag0;
      step();
      if (acc) nxt++;
      if (pop) got.push_back(t);
    end
    in_valid = 1'b0;
    chk("bp_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++) chk("bp_order", got[k], TW'(k + 1));

    // Flush with both entries held and a concurrent input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tag_in    = 8'hA1;
    step();
    tag_in = 8'hA2;
    step();
    chk("fl_full_busy", busy0, 1'b1);
    chk("fl_full_ready", ir0, 1'b0);
    flush  = 1'b1;
    tag_in = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid32", ov0, 1'b0);
    chk("fl_busy32", busy0, 1'b0);
    chk("fl_ready32", ir0, 1'b1);
    chk("fl_out_valid64", ov1, 1'b0);
    step();
    chk("fl_no_ghost", ov0, 1'b0);

    // Flush concurrent with out_ready: entry consumed, stage ends empty
    in_valid = 1'b1;
    tag_in   = 8'h31;
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    tag_in    = 8'hEF;
    chk("flr_tag", tag0, 8'h31);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flr_out_valid", ov0, 1'b0);
    chk("flr_busy", busy0, 1'b0);
    chk("flr_ready", ir0, 1'b1);

    // Async reset in the middle of a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 25'h1FFE001;
    typ       = IMM_I;
    tag_in    = 8'h55;
    step();
    step();
    in_valid = 1'b0;
    chk("ar_pre_busy", busy0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid32", ov0, 1'b0);
    chk("ar_busy32", busy0, 1'b0);
    chk("ar_imm32", {32'b0, imm0}, 64'd0);
    chk("ar_tag32", tag0, 8'd0);
    chk("ar_out_valid64", ov1, 1'b0);
    chk("ar_imm64", imm1, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_ready_after", ir0, 1'b1);

    // Random valid/ready with rare flushes
    xfer[0] = 0;
    xfer[1] = 0;
    cyc = 0;
    while ((xfer[0] < 10000 || xfer[1] < 10000) && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 99) < 85);
      out_ready = ($urandom_range(0, 99) < 80);
      flush     = ($urandom_range(0, 255) == 0);
      instr     = 25'($urandom);
      typ       = 3'($urandom_range(0, 7));
      tag_in    = TW'($urandom);
      step();
      cyc++;
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_xfer32", xfer[0] >= 10000, 1'b1);
    chk("rand_xfer64", xfer[1] >= 10000, 1'b1);
    step();
    step();
    step();
    chk("end_busy32", busy0, 1'b0);
    chk("end_busy64", busy1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
